// File: rtl/tx_fifo36_to_ll8.sv
// Unpacks 36-bit FIFO words (data, SOF, EOF, occupancy) into an 8-bit LocalLink TX byte stream.
// Define TX_FIFO36_FRAME_CHECK_EN to compile in SOF/EOF framing checks driving err.
module tx_fifo36_to_ll8 #(
    parameter int BYTE_ORDER = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  ll_data,
    output logic        ll_sof,
    output logic        ll_eof,
    output logic        ll_src_rdy,
    input  logic        ll_dst_rdy,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [33:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        rd_en;
    logic        in_send;
    logic        at_last;
    logic [1:0]  lane;
    logic [7:0]  sel_byte;

`ifdef TX_FIFO36_FRAME_CHECK_EN
    logic expect_sof_q, expect_sof_d;
    logic err_q, err_d;
`endif

    assign in_send = (state_q == SEND);
    assign at_last = (idx_q == last_q);

    // Lane 3 is data[31:24]; BYTE_ORDER 0 walks lanes 3..0, BYTE_ORDER 1 walks 0..3.
    assign lane     = (BYTE_ORDER == 0) ? (2'd3 - idx_q) : idx_q;
    assign sel_byte = word_q[{lane, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rd_en   = 1'b0;
`ifdef TX_FIFO36_FRAME_CHECK_EN
        expect_sof_d = expect_sof_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                word_d  = fifo_dout[33:0];
                idx_d   = 2'd0;
                last_d  = (fifo_dout[33] && (fifo_dout[35:34] != 2'd0)) ? (fifo_dout[35:34] - 2'd1) : 2'd3;
                state_d = SEND;
`ifdef TX_FIFO36_FRAME_CHECK_EN
                if (expect_sof_q && !fifo_dout[32]) begin
                    // Orphan word outside any frame: drop it rather than emit garbage.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (!expect_sof_q && fifo_dout[32]) err_d = 1'b1;
                    if (fifo_dout[32]) expect_sof_d = 1'b0;
                end
`endif
            end
            SEND: begin
                // A byte moves on a rising edge where ll_src_rdy && ll_dst_rdy; while stalled every ll_* output and the index hold.
                if (ll_dst_rdy) begin
                    if (!at_last) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        rd_en   = !fifo_empty;
                        state_d = fifo_empty ? IDLE : READ;
`ifdef TX_FIFO36_FRAME_CHECK_EN
                        if (word_q[33]) expect_sof_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
`ifdef TX_FIFO36_FRAME_CHECK_EN
            expect_sof_q <= 1'b1;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef TX_FIFO36_FRAME_CHECK_EN
            expect_sof_q <= expect_sof_d;
            err_q        <= err_d;
`endif
        end
    end

    // Gated with rst so the strobe drops in the same cycle reset rises.
    assign fifo_rd_en = rd_en & ~rst;
    assign ll_src_rdy = in_send;
    assign ll_sof     = in_send & word_q[32] & (idx_q == 2'd0);
    assign ll_eof     = in_send & word_q[33] & at_last;
    assign ll_data    = in_send ? sel_byte : 8'h00;
    assign busy       = (state_q != IDLE);

`ifdef TX_FIFO36_FRAME_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
